// File: rtl/pdec_pkg.sv
// ============================================================================
// pdec_pkg -- priority-code constants and the pcode-to-one-hot decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package pdec_pkg;

    typedef logic [2:0] pcode_t;

    localparam pcode_t PC_NONE = 3'b000;
    localparam pcode_t PC_X1   = 3'b001;
    localparam pcode_t PC_X2   = 3'b010;
    localparam pcode_t PC_X3   = 3'b011;
    localparam pcode_t PC_X4   = 3'b100;

    localparam pcode_t PC_LEGAL_MAX = PC_X4;

    // Illegal codes decode to an empty vector; the caller flags them separately.
    function automatic logic [4:1] pdec_decode(input pcode_t c);
        logic [4:1] v;
        v = 4'b0000;
        case (c)
            PC_X1:   v = 4'b0001;
            PC_X2:   v = 4'b0010;
            PC_X3:   v = 4'b0100;
            PC_X4:   v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    function automatic logic pdec_is_illegal(input pcode_t c);
        return (c > PC_LEGAL_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo -- single-clock FIFO with registered storage, no read bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int               PTRW    = $clog2(DEPTH);
    localparam int               CNTW    = PTRW + 1;
    localparam logic [CNTW-1:0]  C_DEPTH = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q,  count_d;

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == C_DEPTH);
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/priority_decoder_stream.sv
// ============================================================================
// priority_decoder_stream -- buffers priority codes and decodes the head entry
// Revision: 1.0
// ============================================================================
`default_nettype none

module priority_decoder_stream
    import pdec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      pcode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:1]      x,
    output logic            code_err,
    output logic [ERRW-1:0] err_count
);

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_illegal;
    pcode_t          w_head;
    logic [ERRW-1:0] err_count_q, err_count_d;

    sync_fifo #(
        .WIDTH (3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (pcode),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Readiness depends only on fullness: a same-cycle pop never frees a slot.
    assign in_ready  = !w_full && !reset;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_illegal = pdec_is_illegal(w_head);

    assign x         = out_valid ? pdec_decode(w_head) : 4'b0000;
    assign code_err  = out_valid && w_illegal;
    assign err_count = err_count_q;

    always_comb begin
        err_count_d = err_count_q;
        if (w_pop && w_illegal && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_priority_decoder_stream.sv
// ============================================================================
// tb_priority_decoder_stream -- scoreboard bench against a queue reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_priority_decoder_stream;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [2:0] pcode;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [4:1] x,         x2;
    logic       code_err,  code_err2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int         exp_q[$];
    int         n_ill;
    int         n_cmp;
    int         n_fail;
    bit         mon_en;

    always #5 clk = ~clk;

    priority_decoder_stream #(.DEPTH(DEPTH), .ERRW(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pcode(pcode), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .code_err(code_err), .err_count(err_count)
    );

    priority_decoder_stream #(.DEPTH(DEPTH), .ERRW(2)) dut_e2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .pcode(pcode), .out_valid(out_valid2), .out_ready(out_ready),
        .x(x2), .code_err(code_err2), .err_count(err_count2)
    );

    function automatic logic [4:1] ref_vec(input int c);
        if (c == 0 || c > 4) return 4'b0000;
        return 4'(1 << (c - 1));
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Record accepted codes in the expected queue.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            n_ill = 0;
        end else if (in_valid && in_ready) begin
            exp_q.push_back(int'(pcode));
        end
    end

    // Compare whatever the DUTs present, then retire the head on a handshake.
    always @(negedge clk) begin : monitor
        int         occ;
        logic [4:1] ex;
        int         ec;
        if (mon_en) begin
            occ = exp_q.size();
            ex  = 4'b0000;
            ec  = 0;
            if (occ > 0) begin
                ex = ref_vec(exp_q[0]);
                ec = (exp_q[0] > 4) ? 1 : 0;
            end
            chk("out_valid",    int'(out_valid),  int'(occ > 0));
            chk("in_ready",     int'(in_ready),   int'(occ < DEPTH && !reset));
            chk("x",            int'(x),          int'(ex));
            chk("code_err",     int'(code_err),   ec);
            chk("err_count",    int'(err_count),  sat(n_ill, 255));
            chk("out_valid_e2", int'(out_valid2), int'(occ > 0));
            chk("in_ready_e2",  int'(in_ready2),  int'(occ < DEPTH && !reset));
            chk("x_e2",         int'(x2),         int'(ex));
            chk("code_err_e2",  int'(code_err2),  ec);
            chk("err_count_e2", int'(err_count2), sat(n_ill, 3));
            if (occ > 0 && out_ready) begin
                if (exp_q[0] > 4) n_ill++;
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        pcode    = c;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        tick();
        chk("drained", int'(out_valid), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        pcode     = 3'b000;
        out_ready = 1'b0;
        n_ill     = 0;
        n_cmp     = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // All legal codes streamed through with a ready sink
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) send(3'(c));
        drain();

        // Backpressure: four fit, the fifth waits for the first pop
        out_ready = 1'b0;
        for (int c = 1; c < 5; c++) send(3'(c));
        fork
            send(3'b011);
            begin
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain();

        // Illegal codes then a legal one
        send(3'b101);
        send(3'b111);
        send(3'b011);
        drain();

        // Enough illegal codes to saturate the narrow counter
        for (int i = 0; i < 5; i++) send(3'(5 + (i % 3)));
        drain();

        // Reset with three entries buffered, then a fresh push
        out_ready = 1'b0;
        send(3'b010);
        send(3'b100);
        send(3'b110);
        pulse_reset();
        out_ready = 1'b1;
        send(3'b001);
        drain();

        // Steady push and pop each cycle around a constant occupancy of two
        out_ready = 1'b0;
        send(3'b001);
        send(3'b010);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            pcode    = 3'($urandom_range(0, 4));
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            pcode     = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        drain();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/priority_decoder_stream.md
PRIORITY_DECODER_STREAM -- requirements
Module: priority_decoder_stream

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter ERRW, default 8, width of illegal-code counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  pcode offered.
REQ-006 SHALL have port in_ready  output  1  block can accept pcode.
REQ-007 SHALL have port pcode  input  3  priority code, 3'b000..3'b100 legal.
REQ-008 SHALL have port out_valid  output  1  decoded vector available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts vector.
REQ-010 SHALL have port x  output  4 ([4:1])  reconstructed one-hot request vector.
REQ-011 SHALL have port code_err  output  1  head entry holds an illegal code.
REQ-012 SHALL have port err_count  output  ERRW  saturating count of illegal codes delivered.

Function
REQ-013 SHALL push pcode into the FIFO on a rising edge where in_valid && in_ready.
REQ-014 SHALL drive in_ready = 1 iff occupancy < DEPTH and reset is low; no push when full, even if a pop occurs in the same cycle.
REQ-015 SHALL drive out_valid = 1 iff occupancy > 0; data pushed into an empty FIFO appears on x one cycle after the push edge (latency 1, no bypass).
REQ-016 SHALL decode the head entry combinationally: 000->0000, 001->0001, 010->0010, 011->0100, 100->1000.
REQ-017 SHALL, for head codes 101/110/111, drive x = 4'b0000 and code_err = 1; code_err = 0 for legal codes and whenever out_valid = 0.
REQ-018 SHALL pop the head on a rising edge where out_valid && out_ready; x and code_err hold stable while out_valid && !out_ready.
REQ-019 SHALL, on simultaneous push and pop with 0 < occupancy < DEPTH, leave occupancy unchanged and preserve FIFO order.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-021 SHALL increment err_count by 1 on each pop of an illegal code, saturating at 2^ERRW-1.
REQ-022 SHALL drive x = 4'b0000 whenever out_valid = 0.

Reset
REQ-023 SHALL, while reset is high on a rising edge, clear pointers, occupancy and err_count to 0 regardless of in_valid/out_ready.
REQ-024 SHALL, in the cycle after reset, present out_valid = 0, x = 0, code_err = 0, err_count = 0, in_ready = 1.
REQ-025 SHALL discard all buffered entries when reset is asserted mid-stream; no stale entry is delivered afterwards.

Structure
REQ-026 SHALL take pcode constants (PC_NONE..PC_X4), the legal-code limit and the decode function from shared package pdec_pkg.
REQ-027 SHALL instantiate one sub-module, sync_fifo (parameters WIDTH=3, DEPTH), holding storage, pointers and occupancy; decode, error flag and counter live in the top.

Verification
REQ-028 SHALL cover: push 000,001,010,011,100 with out_ready=1 -> x = 0000,0001,0010,0100,1000 in order, each one cycle after push, err_count = 0.
REQ-029 SHALL cover: out_ready=0, push 5 codes with DEPTH=4 -> 4 accepted, in_ready = 0 from the cycle after the 4th push, 5th held upstream until first pop.
REQ-030 SHALL cover: push 101,111,011 -> x = 0000/code_err=1 twice then x = 0100/code_err=0; err_count = 2 after the pops.
REQ-031 SHALL cover: ERRW=2, pop 5 illegal codes -> err_count sticks at 3.
REQ-032 SHALL cover: FIFO holding 3 entries, assert reset one cycle -> out_valid = 0, in_ready = 1, err_count = 0 next cycle; subsequent push 001 -> x = 0001.
REQ-033 SHALL cover: continuous push and pop each cycle for 20 cycles with random legal codes -> occupancy constant, output sequence equals input sequence, pointers wrap correctly.
